// File: rtl/regfile_wb_arbiter.sv
// Round-robin writeback arbiter sharing one register-file write port among NREQ sources.
// Optional clear sequencer (zeroes x1..x31) enabled by defining RF_WB_CLEAR_EN.
module regfile_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int NREQ = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_addr,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [XLEN-1:0]      rf_wdata,
  output logic                 busy
`ifdef RF_WB_CLEAR_EN
  ,
  input  logic                 clr_req,
  output logic                 clr_done
`endif
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            rf_we_q, rf_we_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;

  logic            hold_off;
  logic            hit_hi, hit_any, grant;
  logic [PW-1:0]   sel_hi, sel_any, grant_idx;
  logic [4:0]      sel_addr;
  logic [XLEN-1:0] sel_data;

`ifdef RF_WB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t      state_q, state_d;
  logic [4:0]  clr_idx_q, clr_idx_d;
  logic        busy_q, busy_d;
  logic        clr_done_q, clr_done_d;

  // A pending clr_req wins over every requester in the same cycle.
  assign hold_off = (state_q == CLEAR) | clr_req;
  assign busy     = busy_q;
  assign clr_done = clr_done_q;
`else
  assign hold_off = 1'b0;
  assign busy     = 1'b0;
`endif

  // First valid at or above rr_ptr wins; otherwise wrap to the lowest valid index.
  always_comb begin
    hit_hi  = 1'b0;
    hit_any = 1'b0;
    sel_hi  = '0;
    sel_any = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_valid[i]) begin
        if (!hit_any) begin
          hit_any = 1'b1;
          sel_any = PW'(i);
        end
        if (!hit_hi && (i >= int'(rr_ptr_q))) begin
          hit_hi = 1'b1;
          sel_hi = PW'(i);
        end
      end
    end
    grant_idx = hit_hi ? sel_hi : sel_any;
    grant     = hit_any & ~rst & ~hold_off;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) begin
        sel_addr = req_addr[5*i +: 5];
        sel_data = req_data[XLEN*i +: XLEN];
      end
    end
    req_ready = grant ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (grant) begin
      rr_ptr_d = (grant_idx == PW'(NREQ-1)) ? '0 : grant_idx + 1'b1;
      // x0 writes are accepted but never reach the port.
      if (sel_addr != 5'd0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_addr;
        rf_wdata_d = sel_data;
      end
    end
`ifdef RF_WB_CLEAR_EN
    state_d    = state_q;
    clr_idx_d  = clr_idx_q;
    busy_d     = busy_q;
    clr_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_req) begin
          state_d    = CLEAR;
          clr_idx_d  = 5'd1;
          busy_d     = 1'b1;
          rf_we_d    = 1'b1;
          rf_waddr_d = 5'd1;
          rf_wdata_d = '0;
        end
      end
      CLEAR: begin
        if (clr_idx_q == 5'd31) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          clr_idx_d  = clr_idx_q + 5'd1;
          rf_we_d    = 1'b1;
          rf_waddr_d = clr_idx_q + 5'd1;
          rf_wdata_d = '0;
          clr_done_d = (clr_idx_q == 5'd30);
        end
      end
    endcase
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
`ifdef RF_WB_CLEAR_EN
      state_q    <= IDLE;
      clr_idx_q  <= '0;
      busy_q     <= 1'b0;
      clr_done_q <= 1'b0;
`endif
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
`ifdef RF_WB_CLEAR_EN
      state_q    <= state_d;
      clr_idx_q  <= clr_idx_d;
      busy_q     <= busy_d;
      clr_done_q <= clr_done_d;
`endif
    end
  end

  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: stimulus queues expected writes, a monitor pops them.
module tb_regfile_wb_arbiter;
  localparam int XLEN = 64;
  localparam int NREQ = 3;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_addr;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 rf_we;
  logic [4:0]           rf_waddr;
  logic [XLEN-1:0]      rf_wdata;
  logic                 busy;
`ifdef RF_WB_CLEAR_EN
  logic                 clr_req;
  logic                 clr_done;
`endif

  regfile_wb_arbiter #(.XLEN(XLEN), .NREQ(NREQ)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .busy      (busy)
`ifdef RF_WB_CLEAR_EN
    ,
    .clr_req   (clr_req),
    .clr_done  (clr_done)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [63:0] d;
    logic        done;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;
  int  n_vec = 0;
  int  n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic [4:0] a, input logic [63:0] d);
    req_valid[i]          = v;
    req_addr[5*i +: 5]    = a;
    req_data[XLEN*i +: XLEN] = d;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [63:0] d, input logic done);
    exp_q.push_back({a, d, done});
  endtask

  task automatic step(input string name, input logic [NREQ-1:0] exp_rdy);
    @(negedge clk);
    chk(name, 64'(req_ready), 64'(exp_rdy));
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst && rf_we) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_write: got addr %0d data %0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_addr", 64'(rf_waddr), 64'(mon_e.a));
        chk("wr_data", rf_wdata, mon_e.d);
`ifdef RF_WB_CLEAR_EN
        chk("wr_clr_done", 64'(clr_done), 64'(mon_e.done));
`endif
      end
    end
  end

  logic [63:0] dv;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
`ifdef RF_WB_CLEAR_EN
    clr_req   = 1'b0;
`endif
    #12;
    req_valid = '1;
    #1;
    chk("rst_ready", 64'(req_ready), 64'h0);
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_waddr", 64'(rf_waddr), 64'h0);
    chk("rst_wdata", rf_wdata, 64'h0);
    chk("rst_busy", 64'(busy), 64'h0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // contention: grant order 0,1,2,0,1,2
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < NREQ; i++)
        set_req(i, 1'b1, 5'(i + 1), 64'hC0DE_0000_0000_0000 | 64'(c * 16 + i));
      expect_wr(5'((c % 3) + 1), 64'hC0DE_0000_0000_0000 | 64'(c * 16 + (c % 3)), 1'b0);
      step($sformatf("contend_rdy%0d", c), 3'(1 << (c % 3)));
    end
    req_valid = '0;
    step("contend_idle", 3'b000);

    set_req(1, 1'b1, 5'd5, 64'hCAFEBABECAFEBABE);
    expect_wr(5'd5, 64'hCAFEBABECAFEBABE, 1'b0);
    step("single_rdy", 3'b010);
    req_valid = '0;
    step("single_idle", 3'b000);

    // x0 drop: accepted, pointer moves to 1, no write
    set_req(0, 1'b1, 5'd0, 64'hDEAD);
    step("x0_rdy", 3'b001);
    req_valid = '0;
    @(negedge clk);
    chk("x0_no_we", 64'(rf_we), 64'h0);
    chk("x0_idle_rdy", 64'(req_ready), 64'h0);
    @(posedge clk);
    #1;
    set_req(0, 1'b1, 5'd11, 64'h11);
    set_req(1, 1'b1, 5'd12, 64'h12);
    set_req(2, 1'b1, 5'd13, 64'h13);
    expect_wr(5'd12, 64'h12, 1'b0);
    step("x0_ptr_rdy", 3'b010);
    req_valid = '0;
    step("x0_ptr_idle", 3'b000);

    set_req(2, 1'b1, 5'd14, 64'hE);
    expect_wr(5'd14, 64'hE, 1'b0);
    step("wrap_rdy", 3'b100);
    req_valid = '0;

    // back-pressure: requester 2 waits one cycle behind requester 0
    set_req(0, 1'b1, 5'd20, 64'h20);
    set_req(2, 1'b1, 5'd9, 64'h0123456789ABCDEF);
    expect_wr(5'd20, 64'h20, 1'b0);
    step("bp_rdy0", 3'b001);
    req_valid[0] = 1'b0;
    expect_wr(5'd9, 64'h0123456789ABCDEF, 1'b0);
    step("bp_rdy2", 3'b100);
    req_valid = '0;
    step("bp_idle", 3'b000);

    dv = '1;
    set_req(0, 1'b1, 5'd31, dv);
    expect_wr(5'd31, dv, 1'b0);
    step("x31_rdy", 3'b001);
    req_valid = '0;
    step("x31_idle", 3'b000);

`ifdef RF_WB_CLEAR_EN
    set_req(0, 1'b1, 5'd7, 64'h77);
    clr_req = 1'b1;
    for (int k = 1; k <= 31; k++)
      expect_wr(5'(k), 64'h0, (k == 31));
    step("clr_req_rdy", 3'b000);
    clr_req = 1'b0;
    for (int k = 0; k < 31; k++) begin
      @(negedge clk);
      chk($sformatf("clr_rdy%0d", k), 64'(req_ready), 64'h0);
      chk($sformatf("clr_busy%0d", k), 64'(busy), 64'h1);
      @(posedge clk);
      #1;
    end
    expect_wr(5'd7, 64'h77, 1'b0);
    @(negedge clk);
    chk("clr_after_busy", 64'(busy), 64'h0);
    step("clr_after_rdy", 3'b001);
    req_valid = '0;
    step("clr_idle", 3'b000);
`endif

    // async reset during an active grant (rr_ptr is 1 here)
    set_req(0, 1'b1, 5'd1, 64'hA0);
    set_req(1, 1'b1, 5'd2, 64'hA1);
    set_req(2, 1'b1, 5'd3, 64'hA2);
    @(negedge clk);
    chk("prerst_rdy", 64'(req_ready), 64'h2);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_we", 64'(rf_we), 64'h0);
    chk("arst_waddr", 64'(rf_waddr), 64'h0);
    chk("arst_wdata", rf_wdata, 64'h0);
    chk("arst_busy", 64'(busy), 64'h0);
    chk("arst_ready", 64'(req_ready), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("postrst_rdy", 64'(req_ready), 64'h1);
    expect_wr(5'd1, 64'hA0, 1'b0);
    @(posedge clk);
    #1;
    req_valid = '0;
    step("postrst_idle", 3'b000);
    step("final_idle", 3'b000);
    chk("queue_drained", 64'(exp_q.size()), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
